// File: rtl/wb_pkg.sv
// Shared definitions for the write-back / razor replay controller.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } wb_state_e;

    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam int unsigned FLUSH_CYCLES_DEF = 3;
    localparam int unsigned FLUSH_CNT_W      = 4;

endpackage

// File: rtl/wb_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; stops at all-ones.
module wb_sat_counter
    import wb_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_replay_ctrl.sv
// Write-back commit, WB-to-EX forwarding entry and razor squash/flush/redirect sequencer.
// Optional saturating error counter on err_count is built when WB_ERR_CNT_EN is defined.
module wb_replay_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned ERR_CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] regWrAddr_in,
    input  logic        MemtoReg_in,
    input  logic        RegWr_in,
    input  logic        error_in,
    input  logic [31:0] pc_in,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic        flush,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect
`ifdef WB_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    wb_state_e               state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0]             replay_pc_q, replay_pc_d;
    logic                    rf_we_q, rf_we_d;
    logic [4:0]              rf_waddr_q, rf_waddr_d;
    logic [31:0]             rf_wdata_q, rf_wdata_d;
    logic                    fwd_valid_q, fwd_valid_d;
    logic [4:0]              fwd_addr_q, fwd_addr_d;
    logic [31:0]             fwd_data_q, fwd_data_d;
    logic                    flush_q, flush_d;
    logic                    redir_vld_q, redir_vld_d;
    logic [31:0]             redir_pc_q, redir_pc_d;

    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        unused_addr_hi;

    assign waddr          = regWrAddr_in[4:0];
    assign wdata          = MemtoReg_in ? mem_in : alu_in;
    assign unused_addr_hi = ^regWrAddr_in[31:5];

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        replay_pc_d = replay_pc_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        flush_d     = 1'b0;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;

        case (state_q)
            ST_RUN: begin
                if (error_in) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
                    replay_pc_d = pc_in;
                    flush_d     = 1'b1;
                    fwd_valid_d = 1'b0;
                end else if (RegWr_in && (waddr != REG_ZERO)) begin
                    rf_we_d     = 1'b1;
                    rf_waddr_d  = waddr;
                    rf_wdata_d  = wdata;
                    fwd_valid_d = 1'b1;
                    fwd_addr_d  = waddr;
                    fwd_data_d  = wdata;
                end
            end
            // Outputs are registered, so flush/redirect are set up one cycle
            // ahead to line up exactly with the FLUSH/REDIRECT state cycles.
            ST_FLUSH: begin
                if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                    state_d     = ST_REDIRECT;
                    redir_vld_d = 1'b1;
                    redir_pc_d  = replay_pc_q;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                    flush_d     = 1'b1;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            replay_pc_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            flush_q     <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            replay_pc_q <= replay_pc_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            flush_q     <= flush_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign rf_we             = rf_we_q;
    assign rf_waddr          = rf_waddr_q;
    assign rf_wdata          = rf_wdata_q;
    assign fwd_valid         = fwd_valid_q;
    assign fwd_addr          = fwd_addr_q;
    assign fwd_data          = fwd_data_q;
    assign flush             = flush_q;
    assign pc_redirect_valid = redir_vld_q;
    assign pc_redirect       = redir_pc_q;

`ifdef WB_ERR_CNT_EN
    logic err_inc;
    assign err_inc = (state_q == ST_RUN) && error_in;

    wb_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (err_count)
    );
`else
    logic [ERR_CNT_W-1:0] unused_err_cnt;
    assign unused_err_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_replay_ctrl.sv
// Self-checking bench for wb_replay_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_wb_replay_ctrl;

    localparam int unsigned F = 3;
`ifdef WB_ERR_CNT_EN
    localparam int unsigned ECW = 2;
`else
    localparam int unsigned ECW = 16;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_in, alu_in, regWrAddr_in, pc_in;
    logic        MemtoReg_in, RegWr_in, error_in;
    logic        rf_we, fwd_valid, flush, pc_redirect_valid;
    logic [4:0]  rf_waddr, fwd_addr;
    logic [31:0] rf_wdata, fwd_data, pc_redirect;
`ifdef WB_ERR_CNT_EN
    logic [ECW-1:0] err_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: m_pos is the cycle's place in a recovery window
    // (0 = normal operation, 1..F = flush cycles, F+1 = redirect cycle).
    int          m_pos;
    logic [31:0] m_replay;
    logic        m_we, m_fv, m_flush, m_rv;
    logic [4:0]  m_waddr, m_fa;
    logic [31:0] m_wdata, m_fd, m_rpc;
    logic [ECW-1:0] m_ec;

    always #5 clk = ~clk;

    wb_replay_ctrl #(
        .FLUSH_CYCLES (F),
        .ERR_CNT_W    (ECW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_in            (mem_in),
        .alu_in            (alu_in),
        .regWrAddr_in      (regWrAddr_in),
        .MemtoReg_in       (MemtoReg_in),
        .RegWr_in          (RegWr_in),
        .error_in          (error_in),
        .pc_in             (pc_in),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fwd_valid         (fwd_valid),
        .fwd_addr          (fwd_addr),
        .fwd_data          (fwd_data),
        .flush             (flush),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect       (pc_redirect)
`ifdef WB_ERR_CNT_EN
        ,
        .err_count         (err_count)
`endif
    );

    function automatic logic [109:0] dut_vec();
        return {rf_we, m_we ? rf_waddr : 5'd0, m_we ? rf_wdata : 32'd0,
                fwd_valid, fwd_addr, fwd_data, flush, pc_redirect_valid, pc_redirect};
    endfunction

    function automatic logic [109:0] exp_vec();
        return {m_we, m_we ? m_waddr : 5'd0, m_we ? m_wdata : 32'd0,
                m_fv, m_fa, m_fd, m_flush, m_rv, m_rpc};
    endfunction

    task automatic model_step();
        if (!reset) begin
            m_pos = 0; m_replay = '0; m_we = 0; m_waddr = '0; m_wdata = '0;
            m_fv = 0; m_fa = '0; m_fd = '0; m_flush = 0; m_rv = 0; m_rpc = '0; m_ec = '0;
        end else begin
            m_we = 0; m_flush = 0; m_rv = 0;
            if (m_pos == 0) begin
                if (error_in) begin
                    m_pos = 1; m_flush = 1; m_fv = 0; m_replay = pc_in;
                    if (m_ec != {ECW{1'b1}}) m_ec = m_ec + 1'b1;
                end else if (RegWr_in && (regWrAddr_in % 32) != 0) begin
                    m_we = 1; m_waddr = regWrAddr_in[4:0];
                    m_wdata = MemtoReg_in ? mem_in : alu_in;
                    m_fv = 1; m_fa = m_waddr; m_fd = m_wdata;
                end
            end else if (m_pos < F) begin
                m_pos++; m_flush = 1;
            end else if (m_pos == F) begin
                m_pos = F + 1; m_rv = 1; m_rpc = m_replay;
            end else begin
                m_pos = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic m2r, input logic [31:0] addr,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic err, input logic [31:0] pc);
        RegWr_in = wr; MemtoReg_in = m2r; regWrAddr_in = addr;
        mem_in = mem; alu_in = alu; error_in = err; pc_in = pc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        tick();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
             flush, pc_redirect_valid, pc_redirect} !== 110'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
`ifdef WB_ERR_CNT_EN
        vectors++;
        if (err_count !== '0) begin
            miscompares++;
            $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
`endif
        tick();
        vectors++;
        if (flush !== 1'b0 || rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: flush=%b rf_we=%b want 0/0", flush, rf_we);
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        // A clean RUN-state cycle: an error now must start a flush next cycle.
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h0);
        tick();
        vectors++;
        if (flush !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state_run: flush=%b want 1", flush);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < F + 2; i++) tick();
    endtask

    task automatic test_commit();
        drive(1'b1, 1'b1, 32'd7, 32'hDEADBEEF, 32'h1234, 1'b0, 32'h100);
        tick();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data} !==
            {1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd7, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL commit_mem: got we=%b a=%0d d=%h fv=%b fa=%0d fd=%h want 1/7/deadbeef",
                     rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data);
        end
        drive(1'b1, 1'b0, 32'd7, 32'hDEADBEEF, 32'h1234, 1'b0, 32'h104);
        tick();
        vectors++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'h1234 || fwd_data !== 32'h1234) begin
            miscompares++;
            $display("FAIL commit_alu: got we=%b d=%h fd=%h want 1/1234/1234", rf_we, rf_wdata, fwd_data);
        end
        drive(1'b0, 1'b0, 32'd3, 32'h0, 32'h0, 1'b0, 32'h108);
        tick();
        vectors++;
        if (rf_we !== 1'b0 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL commit_single_cycle: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_r0();
        drive(1'b1, 1'b0, 32'h20, 32'h5555, 32'hAAAA, 1'b0, 32'h10C);
        tick();
        vectors++;
        if (rf_we !== 1'b0 || fwd_addr !== 5'd7 || fwd_data !== 32'h1234 || fwd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL r0_write: got we=%b fv=%b fa=%0d fd=%h want 0/1/7/1234",
                     rf_we, fwd_valid, fwd_addr, fwd_data);
        end
    endtask

    task automatic test_recovery();
        int flush_cycles = 0;
        int redirects = 0;
        logic fv_bad = 1'b0;
        drive(1'b1, 1'b1, 32'd9, 32'hCAFE, 32'hBEEF, 1'b1, 32'h40);
        tick();
        vectors++;
        if (rf_we !== 1'b0 || flush !== 1'b1 || fwd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL recov_squash: got we=%b flush=%b fv=%b want 0/1/0", rf_we, flush, fwd_valid);
        end
        flush_cycles = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'd5, 32'h1, 32'h2, i[0], 32'h1000 + i);
            if (i >= F) error_in = 1'b0;
            tick();
            if (flush === 1'b1) flush_cycles++;
            if (pc_redirect_valid === 1'b1) begin
                redirects++;
                vectors++;
                if (pc_redirect !== 32'h40) begin
                    miscompares++;
                    $display("FAIL recov_pc: got %h want 00000040", pc_redirect);
                end
            end
            if (i < F && fwd_valid !== 1'b0) fv_bad = 1'b1;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL recov_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (flush_cycles != F || redirects != 1 || fv_bad) begin
            miscompares++;
            $display("FAIL recov_counts: flush=%0d redirects=%0d fv_bad=%b want %0d/1/0",
                     flush_cycles, redirects, fv_bad, F);
        end
    endtask

    task automatic test_reset_mid_flush();
        int redirects = 0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h80);
        tick();
        error_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (flush !== 1'b0 || pc_redirect_valid !== 1'b0 || pc_redirect !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_flush: flush=%b rv=%b pc=%h want 0/0/0",
                     flush, pc_redirect_valid, pc_redirect);
        end
        reset = 1'b1;
        for (int i = 0; i < F + 3; i++) begin
            tick();
            if (pc_redirect_valid === 1'b1 || flush === 1'b1) redirects++;
        end
        vectors++;
        if (redirects != 0) begin
            miscompares++;
            $display("FAIL reset_mid_flush_after: %0d stray flush/redirect cycles want 0", redirects);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h200);
        tick();
        error_in = 1'b0;
        for (int i = 0; i < F; i++) tick();
        // Now in the REDIRECT cycle; an error presented here is ignored,
        // the next one (first RUN cycle) starts a fresh recovery.
        vectors++;
        if (pc_redirect_valid !== 1'b1 || pc_redirect !== 32'h200) begin
            miscompares++;
            $display("FAIL b2b_redirect1: rv=%b pc=%h want 1/00000200", pc_redirect_valid, pc_redirect);
        end
        error_in = 1'b1; pc_in = 32'h300;
        tick();
        pc_in = 32'h304;
        tick();
        vectors++;
        if (flush !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_flush: flush=%b want 1", flush);
        end
        error_in = 1'b0;
        for (int i = 0; i < F; i++) tick();
        vectors++;
        if (pc_redirect_valid !== 1'b1 || pc_redirect !== 32'h304 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL b2b_redirect2: rv=%b pc=%h want 1/00000304", pc_redirect_valid, pc_redirect);
        end
        tick();
    endtask

    task automatic test_err_count();
`ifdef WB_ERR_CNT_EN
        logic [ECW-1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        for (int r = 0; r < 5; r++) begin
            error_in = 1'b1; pc_in = 32'h500 + 32'(r);
            tick();
            error_in = 1'b0;
            vectors++;
            if (err_count !== want[r] || err_count !== m_ec) begin
                miscompares++;
                $display("FAIL err_count rec %0d: got %0d want %0d", r, err_count, want[r]);
            end
            for (int i = 0; i < F + 1; i++) tick();
        end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? {$urandom, 5'd0} : $urandom,
                  $urandom, $urandom, $urandom_range(0, 9) == 0, $urandom);
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
`ifdef WB_ERR_CNT_EN
            vectors++;
            if (err_count !== m_ec) begin
                miscompares++;
                $display("FAIL random_err_count cyc %0d: got %0d want %0d", c, err_count, m_ec);
            end
`endif
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        m_pos = 0;
        test_reset();
        test_commit();
        test_r0();
        test_recovery();
        test_reset_mid_flush();
        test_back_to_back();
        test_err_count();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
